alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Pipeline stage directly upstream of the 32-bit ALU. Accepts an instruction word
//  plus register-file read data (rs/rt). Decodes opcode/funct into the ALU OPRN code
//  and selects/extends operands OP1/OP2. Registers them behind a valid/ready
//  handshake with a 2-entry skid buffer, so backpressure never drops or duplicates
//  an instruction. ALU output is consumed combinationally downstream of OP1/OP2/OPRN.
// PARAMETERS
//  DATA_W   32  operand width; only 32 is supported
//  OPRN_W   6   ALU operation code width
//  REG_AW   5   register index width (DEST field)
// PORTS
//  CLK        in   1       clock; all state updates on rising edge
//  RST        in   1       synchronous reset, active-high
//  FLUSH      in   1       synchronous discard of all buffered entries
//  IN_VALID   in   1       upstream presents INSTR/RS_DATA/RT_DATA
//  IN_READY   out  1       stage can accept; registered (no comb path from OUT_READY)
//  INSTR      in   32      instruction word: [31:26]op [25:21]rs [20:16]rt [15:11]rd [10:6]shamt [5:0]funct
//  RS_DATA    in   32      rs register value
//  RT_DATA    in   32      rt register value
//  OUT_VALID  out  1       OP1/OP2/OPRN/DEST/ILLEGAL valid toward ALU
//  OUT_READY  in   1       downstream accepts this cycle
//  OP1        out  32      ALU operand 1
//  OP2        out  32      ALU operand 2
//  OPRN       out  6       ALU op: 1 add,2 sub,3 mul,4 srl,5 sll,6 and,7 or,8 nor,9 slt
//  DEST       out  5       writeback register index
//  ILLEGAL    out  1       unsupported encoding; OPRN=0, OP1=OP2=0
// BEHAVIOUR
//  Reset: OUT_VALID=0, OP1=OP2=0, OPRN=0, DEST=0, ILLEGAL=0; state EMPTY;
//   IN_READY=0 while RST high, 1 in first cycle after RST deasserts.
//  Decode (comb on INSTR, captured on accept):
//   op 0x00: funct 0x20 add,0x22 sub,0x2c mul,0x24 and,0x25 or,0x27 nor,0x2a slt:
//     OP1=RS_DATA, OP2=RT_DATA, DEST=rd.
//   op 0x00: funct 0x02 srl(4),0x01 sll(5): OP1=RT_DATA, OP2={27'b0,shamt}, DEST=rd.
//   op 0x08 addi(1), 0x1d muli(3), 0x0a slti(9): OP2=sign-ext imm16; OP1=RS_DATA; DEST=rt.
//   op 0x0c andi(6), 0x0d ori(7): OP2=zero-ext imm16; OP1=RS_DATA; DEST=rt.
//   op 0x0f lui: OPRN=5, OP1={16'b0,imm16}, OP2=32'd16, DEST=rt.
//   any other op/funct: ILLEGAL=1, OPRN=0, OP1=OP2=0, DEST=0; still flows as a token.
//  Handshake: transfer in when IN_VALID&IN_READY; out when OUT_VALID&OUT_READY.
//   Outputs hold stable while OUT_VALID&!OUT_READY. Latency accept->OUT_VALID: 1 cycle.
//  FSM (main reg M drives outputs, skid reg S):
//   EMPTY: in -> M, go ONE.
//   ONE: in&out -> M<=new, stay; in&!out -> S<=new, go TWO; !in&out -> EMPTY.
//   TWO (IN_READY=0): out -> M<=S, go ONE; else hold.
//  IN_READY = (state!=TWO) registered from next-state; OUT_VALID = (state!=EMPTY).
//  Order strictly preserved; throughput 1/cycle when OUT_READY held high.
//  FLUSH: next state EMPTY, OUT_VALID=0 next cycle, any same-cycle input dropped;
//   data regs unchanged. RST has priority over FLUSH.
//  RST mid-transfer: all buffered entries lost, no partial output.
// TESTING
//  add: INSTR=0x00221820 (rs=1,rt=2,rd=3), RS=5, RT=7, OUT_READY=1 -> next cycle
//    OUT_VALID=1, OPRN=1, OP1=5, OP2=7, DEST=3.
//  addi imm 0xFFFF: RS=10 -> OPRN=1, OP2=0xFFFFFFFF; andi same imm -> OPRN=6, OP2=0x0000FFFF.
//  sll shamt=4, RT=0x1 -> OPRN=5, OP1=1, OP2=4; lui imm 0x1234 -> OP1=0x1234, OP2=16, OPRN=5.
//  Backpressure: 3 back-to-back inputs, OUT_READY=0 -> IN_READY drops after 2 accepts;
//    release OUT_READY -> all 3 emerge in order, none duplicated, outputs stable while stalled.
//  FLUSH while TWO -> next cycle OUT_VALID=0, IN_READY=1; following accept emerges alone.
//  Illegal op 0x3f -> ILLEGAL=1, OPRN=0; RST mid-stream -> OUT_VALID=0, all outputs 0.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the 32-bit ALU: decodes instruction + register data into
// OPRN/OP1/OP2/DEST and holds them in a main/skid register pair behind valid/ready.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int OPRN_W = 6,
  parameter int REG_AW = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [31:0]       INSTR,
  input  logic [DATA_W-1:0] RS_DATA,
  input  logic [DATA_W-1:0] RT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OP1,
  output logic [DATA_W-1:0] OP2,
  output logic [OPRN_W-1:0] OPRN,
  output logic [REG_AW-1:0] DEST,
  output logic              ILLEGAL
);

  localparam logic [OPRN_W-1:0] OPR_ADD = OPRN_W'(1);
  localparam logic [OPRN_W-1:0] OPR_SUB = OPRN_W'(2);
  localparam logic [OPRN_W-1:0] OPR_MUL = OPRN_W'(3);
  localparam logic [OPRN_W-1:0] OPR_SRL = OPRN_W'(4);
  localparam logic [OPRN_W-1:0] OPR_SLL = OPRN_W'(5);
  localparam logic [OPRN_W-1:0] OPR_AND = OPRN_W'(6);
  localparam logic [OPRN_W-1:0] OPR_OR  = OPRN_W'(7);
  localparam logic [OPRN_W-1:0] OPR_NOR = OPRN_W'(8);
  localparam logic [OPRN_W-1:0] OPR_SLT = OPRN_W'(9);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_MULI  = 6'h1d;

  localparam logic [5:0] FN_SLL = 6'h01;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  typedef struct packed {
    logic              illegal;
    logic [OPRN_W-1:0] oprn;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } payload_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  logic [5:0]        opc, funct;
  logic [4:0]        rt_idx, rd_idx, shamt;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_sext, imm_zext, shamt_ext;
  logic              unused_rs_field;
  payload_t          dec;

  assign opc       = INSTR[31:26];
  assign rt_idx    = INSTR[20:16];
  assign rd_idx    = INSTR[15:11];
  assign shamt     = INSTR[10:6];
  assign funct     = INSTR[5:0];
  assign imm       = INSTR[15:0];
  assign imm_sext  = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext  = {{(DATA_W-16){1'b0}}, imm};
  assign shamt_ext = {{(DATA_W-5){1'b0}}, shamt};
  // rs index selects RS_DATA upstream; the stage itself never needs it
  assign unused_rs_field = ^INSTR[25:21];

  always_comb begin
    dec = '0;
    case (opc)
      OP_RTYPE: begin
        dec.op1  = RS_DATA;
        dec.op2  = RT_DATA;
        dec.dest = REG_AW'(rd_idx);
        case (funct)
          FN_ADD:  dec.oprn = OPR_ADD;
          FN_SUB:  dec.oprn = OPR_SUB;
          FN_MUL:  dec.oprn = OPR_MUL;
          FN_AND:  dec.oprn = OPR_AND;
          FN_OR:   dec.oprn = OPR_OR;
          FN_NOR:  dec.oprn = OPR_NOR;
          FN_SLT:  dec.oprn = OPR_SLT;
          FN_SRL: begin
            dec.oprn = OPR_SRL;
            dec.op1  = RT_DATA;
            dec.op2  = shamt_ext;
          end
          FN_SLL: begin
            dec.oprn = OPR_SLL;
            dec.op1  = RT_DATA;
            dec.op2  = shamt_ext;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_MULI, OP_SLTI: begin
        dec.oprn = (opc == OP_ADDI) ? OPR_ADD : (opc == OP_MULI) ? OPR_MUL : OPR_SLT;
        dec.op1  = RS_DATA;
        dec.op2  = imm_sext;
        dec.dest = REG_AW'(rt_idx);
      end
      OP_ANDI, OP_ORI: begin
        dec.oprn = (opc == OP_ANDI) ? OPR_AND : OPR_OR;
        dec.op1  = RS_DATA;
        dec.op2  = imm_zext;
        dec.dest = REG_AW'(rt_idx);
      end
      // lui is executed by the ALU as imm16 << 16
      OP_LUI: begin
        dec.oprn = OPR_SLL;
        dec.op1  = imm_zext;
        dec.op2  = DATA_W'(16);
        dec.dest = REG_AW'(rt_idx);
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  state_t   state, state_nxt;
  payload_t main_q, skid_q, main_nxt, skid_nxt;
  logic     in_ready_q, acc, pop;

  assign IN_READY  = in_ready_q & ~RST;
  assign OUT_VALID = (state != EMPTY);
  assign acc       = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    case (state)
      EMPTY: if (acc) begin
        main_nxt  = dec;
        state_nxt = ONE;
      end
      ONE: begin
        if (acc && pop) begin
          main_nxt = dec;
        end else if (acc) begin
          skid_nxt  = dec;
          state_nxt = TWO;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (pop) begin
        main_nxt  = skid_q;
        state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
    // flush only empties the buffer; payload registers keep their last contents
    if (FLUSH) begin
      state_nxt = EMPTY;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      main_q     <= main_nxt;
      skid_q     <= skid_nxt;
      in_ready_q <= (state_nxt != TWO);
    end
  end

  assign OP1     = main_q.op1;
  assign OP2     = main_q.op2;
  assign OPRN    = main_q.oprn;
  assign DEST    = main_q.dest;
  assign ILLEGAL = main_q.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed cases plus random traffic, with a
// scoreboard fed from a table-driven decode model and a decoupled output monitor.
module tb_alu_operand_stage;
  logic        CLK = 1'b0, RST = 1'b1, FLUSH = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b0;
  logic        IN_READY, OUT_VALID, ILLEGAL;
  logic [31:0] INSTR = '0, RS_DATA = '0, RT_DATA = '0, OP1, OP2;
  logic [5:0]  OPRN;
  logic [4:0]  DEST;

  always #5 CLK = ~CLK;

  alu_operand_stage dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INSTR(INSTR), .RS_DATA(RS_DATA), .RT_DATA(RT_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OP1(OP1), .OP2(OP2), .OPRN(OPRN), .DEST(DEST), .ILLEGAL(ILLEGAL)
  );

  typedef struct packed {
    logic        illegal;
    logic [5:0]  oprn;
    logic [4:0]  dest;
    logic [31:0] op1;
    logic [31:0] op2;
  } exp_t;

  // funct / opcode -> ALU op code tables
  int rfun [9] = '{'h20, 'h22, 'h2c, 'h24, 'h25, 'h27, 'h2a, 'h02, 'h01};
  int ropr [9] = '{1, 2, 3, 6, 7, 8, 9, 4, 5};
  int iop  [6] = '{'h08, 'h1d, 'h0a, 'h0c, 'h0d, 'h0f};
  int iopr [6] = '{1, 3, 9, 6, 7, 5};

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t ref_model(input logic [31:0] w, input logic [31:0] rs,
                                     input logic [31:0] rt);
    exp_t        e    = '0;
    int          code = 0;
    logic [15:0] imm  = w[15:0];
    if (w[31:26] == 6'h00) begin
      for (int i = 0; i < 9; i++) if (int'(w[5:0]) == rfun[i]) code = ropr[i];
      if (code == 4 || code == 5) begin
        e.op1 = rt;
        e.op2 = {27'b0, w[10:6]};
      end else begin
        e.op1 = rs;
        e.op2 = rt;
      end
      e.dest = w[15:11];
    end else begin
      for (int i = 0; i < 6; i++) if (int'(w[31:26]) == iop[i]) code = iopr[i];
      e.op1  = rs;
      e.dest = w[20:16];
      if (w[31:26] == 6'h0f) begin
        e.op1 = {16'b0, imm};
        e.op2 = 32'd16;
      end else if (code == 6 || code == 7) begin
        e.op2 = {16'b0, imm};
      end else begin
        e.op2 = 32'($signed(imm));
      end
    end
    if (code == 0) begin
      e = '0;
      e.illegal = 1'b1;
    end else begin
      e.oprn = 6'(code);
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 3))
      0, 1: begin
        w[31:26] = 6'h00;
        w[5:0]   = 6'(rfun[$urandom_range(0, 8)]);
      end
      2:       w[31:26] = 6'(iop[$urandom_range(0, 5)]);
      default: ;
    endcase
    return w;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic check_pkt(input string nm, input exp_t got, input exp_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got ill=%0b oprn=%0d dest=%0d op1=%h op2=%h want ill=%0b oprn=%0d dest=%0d op1=%h op2=%h",
               nm, got.illegal, got.oprn, got.dest, got.op1, got.op2,
               want.illegal, want.oprn, want.dest, want.op1, want.op2);
    end
  endtask

  // samples just before each rising edge; records every accepted instruction
  task automatic push_proc();
    forever begin
      @(negedge CLK);
      #4;
      if (!RST && !FLUSH && IN_VALID && IN_READY)
        sb.push_back(ref_model(INSTR, RS_DATA, RT_DATA));
    end
  endtask

  task automatic mon_proc();
    exp_t cur, held, want;
    bit   held_v = 1'b0;
    forever begin
      @(negedge CLK);
      #4;
      cur = {ILLEGAL, OPRN, DEST, OP1, OP2};
      if (RST) begin
        sb.delete();
        held_v = 1'b0;
      end else begin
        if (OUT_VALID) begin
          if (held_v) check_pkt("stall_hold", cur, held);
          if (OUT_READY) begin
            if (sb.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_out got op1=%h oprn=%0d want no output", cur.op1, cur.oprn);
            end else begin
              want = sb.pop_front();
              check_pkt("sb_out", cur, want);
            end
            held_v = 1'b0;
          end else begin
            held_v = 1'b1;
            held   = cur;
          end
        end else begin
          held_v = 1'b0;
        end
        if (FLUSH) begin
          sb.delete();
          held_v = 1'b0;
        end
      end
    end
  endtask

  // present one instruction and hold IN_VALID until it is taken; returns on the
  // falling edge after the accepting rising edge, with IN_VALID still high
  task automatic send(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
    int n = 0;
    IN_VALID = 1'b1;
    INSTR    = w;
    RS_DATA  = rs;
    RT_DATA  = rt;
    while (!IN_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) begin
      tests++;
      fails++;
      $display("FAIL send_timeout in_ready=0 want=1");
    end
    @(negedge CLK);
  endtask

  task automatic check_zero_outputs(input string nm);
    check({nm, "_valid"}, 32'(OUT_VALID), 0);
    check({nm, "_op1"}, OP1, 0);
    check({nm, "_op2"}, OP2, 0);
    check({nm, "_oprn"}, 32'(OPRN), 0);
    check({nm, "_dest"}, 32'(DEST), 0);
    check({nm, "_illegal"}, 32'(ILLEGAL), 0);
    check({nm, "_in_ready"}, 32'(IN_READY), 0);
  endtask

  initial begin
    int n;
    fork
      push_proc();
      mon_proc();
    join_none

    repeat (3) @(negedge CLK);
    check_zero_outputs("rst");
    RST = 1'b0;
    @(negedge CLK);
    check("rst_release_ready", 32'(IN_READY), 1);

    // add, 1-cycle latency
    OUT_READY = 1'b1;
    send(32'h00221820, 32'd5, 32'd7);
    IN_VALID = 1'b0;
    check("add_valid", 32'(OUT_VALID), 1);
    check("add_oprn", 32'(OPRN), 1);
    check("add_op1", OP1, 5);
    check("add_op2", OP2, 7);
    check("add_dest", 32'(DEST), 3);

    send(32'h2022FFFF, 32'd10, 32'd99);
    IN_VALID = 1'b0;
    check("addi_oprn", 32'(OPRN), 1);
    check("addi_op2", OP2, 32'hFFFFFFFF);
    check("addi_op1", OP1, 10);

    send(32'h3022FFFF, 32'd10, 32'd99);
    IN_VALID = 1'b0;
    check("andi_oprn", 32'(OPRN), 6);
    check("andi_op2", OP2, 32'h0000FFFF);

    send(32'h00021901, 32'h55, 32'd1);
    IN_VALID = 1'b0;
    check("sll_oprn", 32'(OPRN), 5);
    check("sll_op1", OP1, 1);
    check("sll_op2", OP2, 4);

    send(32'h3C021234, 32'h77, 32'h88);
    IN_VALID = 1'b0;
    check("lui_op1", OP1, 32'h1234);
    check("lui_op2", OP2, 16);
    check("lui_oprn", 32'(OPRN), 5);

    send(32'hFC000000, 32'h1, 32'h2);
    IN_VALID = 1'b0;
    check("illegal_flag", 32'(ILLEGAL), 1);
    check("illegal_oprn", 32'(OPRN), 0);
    check("illegal_op1", OP1, 0);
    @(negedge CLK);

    // backpressure: two accepted, third stalls until release
    OUT_READY = 1'b0;
    send(gen_instr(), $urandom, $urandom);
    send(gen_instr(), $urandom, $urandom);
    check("bp_ready_low", 32'(IN_READY), 0);
    INSTR = gen_instr();
    repeat (3) @(negedge CLK);
    check("bp_ready_stall", 32'(IN_READY), 0);
    check("bp_valid_stall", 32'(OUT_VALID), 1);
    OUT_READY = 1'b1;
    send(INSTR, RS_DATA, RT_DATA);
    IN_VALID = 1'b0;
    repeat (4) @(negedge CLK);
    check("bp_drain", 32'(sb.size()), 0);

    // flush while holding two entries
    OUT_READY = 1'b0;
    send(gen_instr(), $urandom, $urandom);
    send(gen_instr(), $urandom, $urandom);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH    = 1'b0;
    IN_VALID = 1'b0;
    check("flush_valid", 32'(OUT_VALID), 0);
    check("flush_ready", 32'(IN_READY), 1);
    OUT_READY = 1'b1;
    send(32'h00221820, 32'd11, 32'd22);
    IN_VALID = 1'b0;
    check("flush_next_valid", 32'(OUT_VALID), 1);
    check("flush_next_op1", OP1, 11);
    repeat (3) @(negedge CLK);
    check("flush_alone", 32'(sb.size()), 0);

    // reset with entries buffered
    OUT_READY = 1'b0;
    send(32'h00221820, 32'd3, 32'd4);
    send(32'h2022FFFF, 32'd6, 32'd8);
    IN_VALID = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check_zero_outputs("rst_mid");
    RST = 1'b0;
    @(negedge CLK);

    for (int c = 0; c < 800; c++) begin
      IN_VALID  = ($urandom_range(0, 3) != 0);
      INSTR     = gen_instr();
      RS_DATA   = $urandom;
      RT_DATA   = $urandom;
      OUT_READY = ($urandom_range(0, 2) != 0);
      FLUSH     = ($urandom_range(0, 49) == 0);
      RST       = ($urandom_range(0, 199) == 0);
      @(negedge CLK);
    end

    IN_VALID  = 1'b0;
    FLUSH     = 1'b0;
    RST       = 1'b0;
    OUT_READY = 1'b1;
    n = 0;
    while ((sb.size() != 0 || OUT_VALID) && n < 10) begin
      @(negedge CLK);
      n++;
    end
    check("final_drain", 32'(sb.size()), 0);
    check("final_idle", 32'(OUT_VALID), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
